// File: rtl/systolic_out_drain.sv
// systolic_out_drain: drains words from the systolic output buffer onto a
// valid/ready stream with a last flag. A 2-entry skid FIFO absorbs the
// 1-cycle buffer read latency, so stream back-pressure never loses data.
// Optional macro: SYSTOLIC_OUT_DRAIN_STALL_CNT_EN enables the stall counter.
module systolic_out_drain #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DMA_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH:0]       length,
  output logic                      busy,
  output logic                      done,
  input  logic                      buf_valid,
  output logic                      buf_ren,
  output logic [ADDR_WIDTH-1:0]     buf_raddr,
  input  logic [DMA_DATA_WIDTH-1:0] buf_rdata,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DMA_DATA_WIDTH-1:0] m_data,
  output logic                      m_last,
  output logic [15:0]               stall_cnt
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     base_reg;
  logic [ADDR_WIDTH:0]       len_reg;
  logic [ADDR_WIDTH:0]       issued_reg;
  logic                      inflight_reg;
  logic                      inflight_last_reg;

  // Skid FIFO: two entries of {last, data} with 1-bit pointers.
  logic [DMA_DATA_WIDTH-1:0] fifo_data_reg [2];
  logic                      fifo_last_reg [2];
  logic                      wr_ptr_reg;
  logic                      rd_ptr_reg;
  logic [1:0]                count_reg;

  logic                      start_acc;
  logic [ADDR_WIDTH:0]       len_clamped;
  logic                      pop;
  logic [2:0]                occupancy;
  logic                      room;
  logic                      issue;
  logic                      issue_last;
  logic                      last_beat;

  // Command acceptance, read-issue decision and stream handshake.
  always_comb begin
    start_acc   = (state_reg == ST_IDLE) && start;
    len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    m_valid     = (count_reg != 2'd0);
    m_data      = fifo_data_reg[rd_ptr_reg];
    m_last      = m_valid && fifo_last_reg[rd_ptr_reg];
    pop         = m_valid && m_ready;
    // Words held plus the word in flight, less the one leaving this cycle,
    // must stay under two so the returning word always has a slot.
    occupancy   = {1'b0, count_reg} + {2'b00, inflight_reg};
    room        = occupancy < (3'd2 + {2'b00, pop});
    issue       = (state_reg == ST_RUN) && (issued_reg < len_reg) && buf_valid && room;
    issue_last  = (issued_reg == (len_reg - ONE));
    last_beat   = pop && m_last;
    buf_ren     = issue;
    buf_raddr   = base_reg + issued_reg[ADDR_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (len_clamped == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_beat) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch, issue counter, in-flight tracking and FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_reg          <= '0;
      len_reg           <= '0;
      issued_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      count_reg         <= 2'd0;
    end else begin
      if (start_acc) begin
        base_reg   <= base_addr;
        len_reg    <= len_clamped;
        issued_reg <= '0;
      end else if (issue) begin
        issued_reg <= issued_reg + ONE;
      end
      inflight_reg      <= issue;
      inflight_last_reg <= issue_last;
      if (inflight_reg) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

  // FIFO storage: the returning buffer word lands in the slot at wr_ptr.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          fifo_data_reg[gi] <= '0;
          fifo_last_reg[gi] <= 1'b0;
        end else if (inflight_reg && (wr_ptr_reg == 1'(gi))) begin
          fifo_data_reg[gi] <= buf_rdata;
          fifo_last_reg[gi] <= inflight_last_reg;
        end
      end
    end
  endgenerate

`ifdef SYSTOLIC_OUT_DRAIN_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Saturating count of RUN cycles where a word waits on the DMA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= 16'd0;
    end else if (start_acc) begin
      stall_cnt_reg <= 16'd0;
    end else if ((state_reg == ST_RUN) && m_valid && !m_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_out_drain.sv
// Directed testbench for systolic_out_drain with a 32-word buffer model.
module tb_systolic_out_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  length;
  logic        busy;
  logic        done;
  logic        buf_valid;
  logic        buf_ren;
  logic [4:0]  buf_raddr;
  logic [31:0] buf_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [15:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] tb_mem [32];

  // Monitor state (written only by the monitor process).
  logic [32:0] beat_q [$];
  logic [4:0]  addr_q [$];
  int          out_cnt   = 0;
  int          ren_viol  = 0;
  int          stab_viol = 0;
  int          stalls    = 0;
  int          done_cnt  = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word  = '0;

  always #5 clk = ~clk;

  systolic_out_drain #(.ADDR_WIDTH(5), .DMA_DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .buf_valid(buf_valid), .buf_ren(buf_ren),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .stall_cnt(stall_cnt)
  );

  // Buffer model: data returns the cycle after the read enable.
  always @(posedge clk) begin
    if (buf_ren) buf_rdata <= tb_mem[buf_raddr];
  end

  // Stream/read monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      out_cnt    <= 0;
      prev_stall <= 1'b0;
      stalls     <= 0;
    end else begin
      if (buf_ren) begin
        addr_q.push_back(buf_raddr);
        if ((out_cnt - ((m_valid && m_ready) ? 1 : 0)) >= 2) ren_viol <= ren_viol + 1;
      end
      if (m_valid && m_ready) beat_q.push_back({m_last, m_data});
      out_cnt <= out_cnt + (buf_ren ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (prev_stall && (!m_valid || ({m_last, m_data} !== prev_word))) stab_viol <= stab_viol + 1;
      prev_stall <= m_valid && !m_ready;
      prev_word  <= {m_last, m_data};
      if (start && !busy) stalls <= 0;
      else if (busy && m_valid && !m_ready) stalls <= stalls + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stall counter value given the monitor's stall count.
  function automatic logic [15:0] exp_stall(input int s);
`ifdef SYSTOLIC_OUT_DRAIN_STALL_CNT_EN
    return 16'(s);
`else
    return 16'd0;
`endif
  endfunction

  // Run one command. mode 0: ready held; 1: ready pattern 1,0,0,1,0,1;
  // 2: buf_valid low for 5 cycles after the 2nd issue.
  task automatic run_xfer(input logic [4:0] b, input logic [5:0] l, input int mode,
                          output int cycles, output int issues);
    logic [5:0] pat;
    int gap;
    int dones;
    pat = 6'b101001;
    gap = 0; dones = 0; issues = 0; cycles = 0;
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1; m_ready = 1'b1; buf_valid = 1'b1;
    for (int c = 1; c < 300; c++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      m_ready = (mode == 1) ? pat[(c-1) % 6] : 1'b1;
      if (gap > 0) begin buf_valid = 1'b0; gap--; end
      else buf_valid = 1'b1;
      @(negedge clk);
      if (!buf_valid) chk($sformatf("ren_paused_c%0d", c), buf_ren, 1'b0);
      if (buf_ren) begin
        issues++;
        if (mode == 2 && issues == 2) gap = 5;
      end
      if (done) begin dones++; cycles = c; break; end
    end
    chk("done_seen", dones, 1);
    m_ready = 1'b1; buf_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  task automatic check_beats(input string tag, input logic [4:0] b, input int l, input int q0);
    int n;
    n = beat_q.size() - q0;
    chk({tag, "_count"}, n, l);
    for (int i = 0; i < l && i < n; i++) begin
      chk($sformatf("%s_beat%0d", tag, i), beat_q[q0+i],
          {(i == l-1), tb_mem[5'(b + 5'(i))]});
    end
  endtask

  initial begin
    int cyc, iss, q0, a0, d0;
    for (int i = 0; i < 32; i++) tb_mem[i] = 32'hC000_0000 + i;
    tb_mem[0] = 32'h11; tb_mem[1] = 32'h22; tb_mem[2] = 32'h33; tb_mem[3] = 32'h44;
    tb_mem[30] = 32'hA0; tb_mem[31] = 32'hA1;
    rst = 1'b0; start = 1'b0; base_addr = '0; length = '0; buf_valid = 1'b1; m_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ren", buf_ren, 0);
    chk("rst_mvalid", m_valid, 0); chk("rst_mlast", m_last, 0);
    chk("rst_raddr", buf_raddr, 0); chk("rst_mdata", m_data, 0); chk("rst_stall", stall_cnt, 0);
    rst = 1'b1;

    // Test 1: base 0, length 4, cycle-exact timing.
    q0 = beat_q.size();
    @(posedge clk); #1;
    base_addr = 5'd0; length = 6'd4; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk($sformatf("t1_ren_c%0d", c), buf_ren, (c >= 1 && c <= 4));
      chk($sformatf("t1_valid_c%0d", c), m_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk($sformatf("t1_data_c%0d", c), m_data, tb_mem[c-3]);
      chk($sformatf("t1_last_c%0d", c), m_last, (c == 6));
      chk($sformatf("t1_done_c%0d", c), done, (c == 7));
      chk($sformatf("t1_busy_c%0d", c), busy, (c <= 7));
    end
    check_beats("t1", 5'd0, 4, q0);

    // Test 2: address wrap.
    q0 = beat_q.size(); a0 = addr_q.size();
    run_xfer(5'd30, 6'd4, 0, cyc, iss);
    chk("t2_addr_count", addr_q.size() - a0, 4);
    if (addr_q.size() - a0 >= 4) begin
      chk("t2_addr0", addr_q[a0], 5'd30); chk("t2_addr1", addr_q[a0+1], 5'd31);
      chk("t2_addr2", addr_q[a0+2], 5'd0); chk("t2_addr3", addr_q[a0+3], 5'd1);
    end
    check_beats("t2", 5'd30, 4, q0);

    // Test 3: toggling back-pressure.
    q0 = beat_q.size();
    run_xfer(5'd10, 6'd6, 1, cyc, iss);
    check_beats("t3", 5'd10, 6, q0);
    chk("t3_issues", iss, 6);
    chk("t3_stall_cnt", stall_cnt, exp_stall(stalls));

    // Test 4: zero length.
    q0 = beat_q.size(); a0 = addr_q.size();
    run_xfer(5'd5, 6'd0, 0, cyc, iss);
    chk("t4_done_cycle", cyc, 1);
    chk("t4_no_reads", addr_q.size() - a0, 0);
    chk("t4_no_beats", beat_q.size() - q0, 0);

    // Test 5: buf_valid gap after the 2nd issue.
    q0 = beat_q.size();
    run_xfer(5'd20, 6'd5, 2, cyc, iss);
    chk("t5_issues", iss, 5);
    check_beats("t5", 5'd20, 5, q0);

    // Test 6: over-range length clamps to the buffer depth.
    q0 = beat_q.size();
    run_xfer(5'd4, 6'd50, 0, cyc, iss);
    check_beats("t6", 5'd4, 32, q0);

    // Test 7: reset while two words are buffered.
    d0 = done_cnt;
    @(posedge clk); #1;
    base_addr = 5'd8; length = 6'd6; start = 1'b1; m_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("t7_held_valid", m_valid, 1'b1);
    chk("t7_held_ren", buf_ren, 1'b0);
    #2; rst = 1'b0; #1;
    chk("t7_rst_busy", busy, 0); chk("t7_rst_valid", m_valid, 0); chk("t7_rst_ren", buf_ren, 0);
    chk("t7_rst_last", m_last, 0); chk("t7_rst_data", m_data, 0); chk("t7_rst_raddr", buf_raddr, 0);
    chk("t7_rst_stall", stall_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_no_done", done_cnt, d0);
    q0 = beat_q.size();
    run_xfer(5'd3, 6'd2, 0, cyc, iss);
    check_beats("t7", 5'd3, 2, q0);

    chk("ren_occupancy_viol", ren_viol, 0);
    chk("stream_stability_viol", stab_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
